javk_alu_ctrl: RTL and testbench

JAVK CPU control unit combined with the 8-bit ALU. A two-state FETCH/EXEC sequencer decodes the instruction byte presented by the core and drives the register-select, 16-bit move, nibble-load and memory-write strobes. The ALU computes on accumulator A and a selected register, and registers its result and flags at the end of EXEC. The block sits between the core's instruction register/register file and the address/data bus logic.

---
 rtl/javk_alu_ctrl.sv | 159 +++++++++++++++
 tb/tb_javk_alu_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/javk_alu_ctrl.sv
// JAVK control sequencer (FETCH/EXEC) with an 8-bit ALU whose result and flags are registered at the end of EXEC.
// Optional HLT instruction and HALT state are enabled by defining JAVK_HALT_EN.
module javk_alu_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       fetch,
   output logic [2:0] alu_op,
   output logic [2:0] alu_shamt,
   output logic       alu_clk,
   output logic [7:0] alu_out,
   output logic [3:0] flags,
   output logic [3:0] reg_sel,
   output logic [3:0] nibble_out,
   output logic       nib_wr,
   output logic       nib_hi,
   output logic [1:0] reg16_src,
   output logic [1:0] reg16_dst,
   output logic       mov16,
   output logic       ld,
   output logic       we
);

`ifdef JAVK_HALT_EN
   typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_t;
`else
   typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1} state_t;
`endif

   state_t     state;
   state_t     state_nxt;
   logic [7:0] ir;
   logic [7:0] result;
   logic       carry;
   logic       ovf;
   logic [8:0] sum;
   logic [8:0] diff;
   logic [8:0] shl;
   logic [8:0] shr;
   logic [15:0] rot;

   always_ff @(posedge clk) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = FETCH;
      case (state)
         FETCH: state_nxt = EXEC;
`ifdef JAVK_HALT_EN
         EXEC:  state_nxt = (ir == 8'hFF) ? HALT : FETCH;
         HALT:  state_nxt = HALT;
`else
         EXEC:  state_nxt = FETCH;
`endif
         default: state_nxt = FETCH;
      endcase
   end

   // Decoded strobes exist only in EXEC and are forced off while rst is high.
   always_comb begin
      fetch      = (state == FETCH) || rst;
      alu_op     = 3'd0;
      alu_shamt  = 3'd0;
      alu_clk    = 1'b0;
      reg_sel    = 4'd0;
      nibble_out = 4'd0;
      nib_wr     = 1'b0;
      nib_hi     = 1'b0;
      reg16_src  = 2'd0;
      reg16_dst  = 2'd0;
      mov16      = 1'b0;
      ld         = 1'b0;
      we         = 1'b0;
      if (state == EXEC && !rst) begin
         if (!ir[7]) begin
            alu_op    = ir[6:4];
            reg_sel   = ir[3:0];
            alu_clk   = 1'b1;
            alu_shamt = {2'b00, ir[6] & (ir[5] | ir[4])};
         end else if (ir[6:5] == 2'b00) begin
            if (ir[4:3] != 2'b00) begin
               alu_op    = {1'b1, ir[4:3]};
               alu_shamt = ir[2:0];
               alu_clk   = 1'b1;
            end
         end else if (ir[6:5] == 2'b01) begin
            nibble_out = ir[3:0];
            nib_wr     = 1'b1;
            nib_hi     = ir[4];
         end else if (ir[7:4] == 4'hE) begin
            reg16_src = ir[3:2];
            reg16_dst = ir[1:0];
            mov16     = 1'b1;
         end else if (ir == 8'hF0) begin
            ld = 1'b1;
         end else if (ir == 8'hF1) begin
            we = 1'b1;
         end
      end
   end

   // Shifts use a spare ninth bit so the last bit shifted out lands in a fixed position.
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      shl    = {1'b0, a} << alu_shamt;
      shr    = {a, 1'b0} >> alu_shamt;
      rot    = {a, a} >> alu_shamt;
      result = 8'd0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (alu_op)
         3'd0: begin
            result = sum[7:0];
            carry  = sum[8];
            ovf    = (a[7] == b[7]) && (sum[7] != a[7]);
         end
         3'd1: begin
            result = diff[7:0];
            carry  = diff[8];
            ovf    = (a[7] != b[7]) && (diff[7] != a[7]);
         end
         3'd2: result = a & b;
         3'd3: result = a | b;
         3'd4: result = a ^ b;
         3'd5: begin
            result = shl[7:0];
            carry  = shl[8];
         end
         3'd6: begin
            result = shr[8:1];
            carry  = shr[0];
         end
         default: begin
            result = rot[7:0];
            carry  = rot[7];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir      <= 8'd0;
         alu_out <= 8'd0;
         flags   <= 4'd0;
      end else begin
         if (state == FETCH) ir <= instr;
         if (alu_clk) begin
            alu_out <= result;
            flags   <= {carry, ovf, result[7], result == 8'd0};
         end
      end
   end

endmodule

// File: tb/tb_javk_alu_ctrl.sv
// Directed self-checking bench for javk_alu_ctrl: decode strobes in EXEC, registered ALU results one cycle later.
module tb_javk_alu_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] instr;
   logic [7:0] a;
   logic [7:0] b;
   logic       fetch;
   logic [2:0] alu_op;
   logic [2:0] alu_shamt;
   logic       alu_clk;
   logic [7:0] alu_out;
   logic [3:0] flags;
   logic [3:0] reg_sel;
   logic [3:0] nibble_out;
   logic       nib_wr;
   logic       nib_hi;
   logic [1:0] reg16_src;
   logic [1:0] reg16_dst;
   logic       mov16;
   logic       ld;
   logic       we;
   logic [4:0] strobes;

   int assertCount = 0;
   int failCount   = 0;

   javk_alu_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .instr      (instr),
      .a          (a),
      .b          (b),
      .fetch      (fetch),
      .alu_op     (alu_op),
      .alu_shamt  (alu_shamt),
      .alu_clk    (alu_clk),
      .alu_out    (alu_out),
      .flags      (flags),
      .reg_sel    (reg_sel),
      .nibble_out (nibble_out),
      .nib_wr     (nib_wr),
      .nib_hi     (nib_hi),
      .reg16_src  (reg16_src),
      .reg16_dst  (reg16_dst),
      .mov16      (mov16),
      .ld         (ld),
      .we         (we)
   );

   assign strobes = {alu_clk, nib_wr, mov16, ld, we};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] i, input logic [7:0] av, input logic [7:0] bv);
      instr = i;
      a     = av;
      b     = bv;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(8'hC0, 8'h00, 8'h00);
      step();
      checkOutput("rst_fetch", {15'd0, fetch}, 16'd1);
      checkOutput("rst_strobes", {11'd0, strobes}, 16'd0);
      step();
      rst = 1'b0;
      checkOutput("post_rst_fetch", {15'd0, fetch}, 16'd1);
      checkOutput("post_rst_alu_out", {8'd0, alu_out}, 16'h00);
      checkOutput("post_rst_flags", {12'd0, flags}, 16'h0);
      checkOutput("post_rst_strobes", {11'd0, strobes}, 16'd0);

      // NOP instruction so fetch can be watched toggling without ALU side effects
      step(); checkOutput("alt_fetch0", {15'd0, fetch}, 16'd0);
      step(); checkOutput("alt_fetch1", {15'd0, fetch}, 16'd1);
      step(); checkOutput("alt_fetch2", {15'd0, fetch}, 16'd0);
      step(); checkOutput("alt_fetch3", {15'd0, fetch}, 16'd1);

      applyStimulus(8'h03, 8'h7F, 8'h01);
      step();
      checkOutput("add_fetch", {15'd0, fetch}, 16'd0);
      checkOutput("add_reg_sel", {12'd0, reg_sel}, 16'd3);
      checkOutput("add_op", {13'd0, alu_op}, 16'd0);
      checkOutput("add_shamt", {13'd0, alu_shamt}, 16'd0);
      checkOutput("add_strobes", {11'd0, strobes}, 16'b10000);
      step();
      checkOutput("add_out", {8'd0, alu_out}, 16'h80);
      checkOutput("add_flags", {12'd0, flags}, 16'b0110);
      checkOutput("add_back_fetch", {15'd0, fetch}, 16'd1);
      checkOutput("add_back_strobes", {11'd0, strobes}, 16'd0);

      applyStimulus(8'h01, 8'hFF, 8'h01);
      step(); step();
      checkOutput("addc_out", {8'd0, alu_out}, 16'h00);
      checkOutput("addc_flags", {12'd0, flags}, 16'b1001);

      applyStimulus(8'h15, 8'h05, 8'h05);
      step();
      checkOutput("sub_op", {13'd0, alu_op}, 16'd1);
      checkOutput("sub_reg_sel", {12'd0, reg_sel}, 16'd5);
      step();
      checkOutput("sub0_out", {8'd0, alu_out}, 16'h00);
      checkOutput("sub0_flags", {12'd0, flags}, 16'b0001);
      applyStimulus(8'h15, 8'h01, 8'h02);
      step(); step();
      checkOutput("subb_out", {8'd0, alu_out}, 16'hFF);
      checkOutput("subb_flags", {12'd0, flags}, 16'b1010);

      applyStimulus(8'hA5, 8'h00, 8'h00);
      step();
      checkOutput("nibl_val", {12'd0, nibble_out}, 16'd5);
      checkOutput("nibl_hi", {15'd0, nib_hi}, 16'd0);
      checkOutput("nibl_strobes", {11'd0, strobes}, 16'b01000);
      step();
      checkOutput("nibl_after", {11'd0, strobes}, 16'd0);

      applyStimulus(8'hB7, 8'h00, 8'h00);
      step();
      checkOutput("nibh_val", {12'd0, nibble_out}, 16'd7);
      checkOutput("nibh_hi", {15'd0, nib_hi}, 16'd1);
      step();

      applyStimulus(8'hE6, 8'h00, 8'h00);
      step();
      checkOutput("mov_src", {14'd0, reg16_src}, 16'd1);
      checkOutput("mov_dst", {14'd0, reg16_dst}, 16'd2);
      checkOutput("mov_strobes", {11'd0, strobes}, 16'b00100);
      step();

      applyStimulus(8'hF0, 8'h00, 8'h00);
      step();
      checkOutput("ld_strobes", {11'd0, strobes}, 16'b00010);
      step();

      applyStimulus(8'hF1, 8'h00, 8'h00);
      step();
      checkOutput("we_strobes", {11'd0, strobes}, 16'b00001);
      step();
      checkOutput("we_after", {11'd0, strobes}, 16'd0);
      checkOutput("we_hold_out", {8'd0, alu_out}, 16'hFF);
      checkOutput("we_hold_flags", {12'd0, flags}, 16'b1010);

      applyStimulus(8'h20, 8'hF0, 8'h0F);
      step(); step();
      checkOutput("and_out", {8'd0, alu_out}, 16'h00);
      checkOutput("and_flags", {12'd0, flags}, 16'b0001);

      applyStimulus(8'h30, 8'h80, 8'h01);
      step(); step();
      checkOutput("or_out", {8'd0, alu_out}, 16'h81);
      checkOutput("or_flags", {12'd0, flags}, 16'b0010);

      applyStimulus(8'h40, 8'hFF, 8'h0F);
      step(); step();
      checkOutput("xor_out", {8'd0, alu_out}, 16'hF0);
      checkOutput("xor_flags", {12'd0, flags}, 16'b0010);

      applyStimulus(8'h52, 8'h81, 8'h00);
      step();
      checkOutput("shlr_op", {13'd0, alu_op}, 16'd5);
      checkOutput("shlr_shamt", {13'd0, alu_shamt}, 16'd1);
      step();
      checkOutput("shlr_out", {8'd0, alu_out}, 16'h02);
      checkOutput("shlr_flags", {12'd0, flags}, 16'b1000);

      applyStimulus(8'h92, 8'h06, 8'h00);
      step();
      checkOutput("shr_op", {13'd0, alu_op}, 16'd6);
      step();
      checkOutput("shr_out", {8'd0, alu_out}, 16'h01);
      checkOutput("shr_flags", {12'd0, flags}, 16'b1000);

      applyStimulus(8'h8C, 8'h3C, 8'h00);
      step();
      checkOutput("shl_op", {13'd0, alu_op}, 16'd5);
      checkOutput("shl_shamt", {13'd0, alu_shamt}, 16'd4);
      step();
      checkOutput("shl_out", {8'd0, alu_out}, 16'hC0);
      checkOutput("shl_flags", {12'd0, flags}, 16'b1010);

      applyStimulus(8'h84, 8'hFF, 8'hFF);
      step();
      checkOutput("nop_shift_strobes", {11'd0, strobes}, 16'd0);
      step();
      checkOutput("nop_shift_out", {8'd0, alu_out}, 16'hC0);
      checkOutput("nop_shift_flags", {12'd0, flags}, 16'b1010);

      applyStimulus(8'h9B, 8'h81, 8'h00);
      step();
      checkOutput("ror_op", {13'd0, alu_op}, 16'd7);
      checkOutput("ror_shamt", {13'd0, alu_shamt}, 16'd3);
      step();
      checkOutput("ror_out", {8'd0, alu_out}, 16'h30);
      checkOutput("ror_flags", {12'd0, flags}, 16'b0000);

      // Reset arrives while the ADD is in EXEC; its result must never appear
      applyStimulus(8'h03, 8'h7F, 8'h01);
      step();
      checkOutput("rstx_exec_strobes", {11'd0, strobes}, 16'b10000);
      rst = 1'b1;
      #1;
      checkOutput("rstx_gated_strobes", {11'd0, strobes}, 16'd0);
      checkOutput("rstx_gated_fetch", {15'd0, fetch}, 16'd1);
      step();
      rst = 1'b0;
      checkOutput("rstx_out", {8'd0, alu_out}, 16'h00);
      checkOutput("rstx_flags", {12'd0, flags}, 16'h0);
      checkOutput("rstx_fetch", {15'd0, fetch}, 16'd1);
      step();
      checkOutput("rstx_next_exec", {15'd0, fetch}, 16'd0);
      step();
      checkOutput("rstx_add_out", {8'd0, alu_out}, 16'h80);

      applyStimulus(8'hFF, 8'h12, 8'h34);
      step();
      checkOutput("hlt_exec_strobes", {11'd0, strobes}, 16'd0);
      step();
`ifdef JAVK_HALT_EN
      checkOutput("halt_fetch0", {15'd0, fetch}, 16'd0);
      checkOutput("halt_strobes", {11'd0, strobes}, 16'd0);
      step(); step();
      checkOutput("halt_fetch1", {15'd0, fetch}, 16'd0);
      checkOutput("halt_hold_out", {8'd0, alu_out}, 16'h80);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("halt_exit_fetch", {15'd0, fetch}, 16'd1);
`else
      checkOutput("ff_nop_fetch", {15'd0, fetch}, 16'd1);
      checkOutput("ff_nop_out", {8'd0, alu_out}, 16'h80);
      checkOutput("ff_nop_flags", {12'd0, flags}, 16'b0110);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
